// File: rtl/pll_clk_monitor.sv
//-----------------------------------------------------------------------------
// pll_clk_monitor
//
// Purpose
//   Lock and frequency checker placed directly downstream of the PLL2
//   instance. It filters the PLL lock indication and counts rising edges of
//   one PLL output clock over fixed windows of the monitor clock. Each
//   completed window is range-checked against [EXP_MIN, EXP_MAX]. Frequency
//   violations and losses of lock are accumulated in a saturating error
//   counter. The block is used by the PLL bench and for board bring-up.
//
// Ports
//   clk_tb      in   1      monitor clock; must run faster than 2x clk_meas
//   rst_n       in   1      asynchronous, active-low reset
//   pll_lock    in   1      PLL lock, asynchronous to clk_tb
//   clk_meas    in   1      PLL output clock under test, asynchronous
//   meas_en     in   1      enables measurement and error accumulation
//   lock_ok     out  1      filtered lock
//   lock_lost   out  1      one-cycle pulse after lock_ok falls
//   meas_cnt    out  CNT_W  edge count of the last completed window
//   meas_valid  out  1      one-cycle pulse when meas_cnt/freq_err update
//   freq_err    out  1      last completed window was out of range
//   err_cnt     out  ERR_W  saturating error event count
//   state       out  2      FSM state: 0 IDLE, 1 WAIT_LOCK, 2 MEASURE
//
// Result interface
//   meas_valid is a pure valid strobe with no ready. It is high for exactly
//   one clk_tb cycle. In that cycle meas_cnt and freq_err carry the new
//   window result, and err_cnt already includes that window's error. The
//   consumer must sample the result in that cycle. meas_cnt and freq_err
//   then hold until the next completed window or until reset.
//-----------------------------------------------------------------------------
module pll_clk_monitor #(
  parameter int WIN_CYCLES = 1000,
  parameter int CNT_W      = 16,
  parameter int EXP_MIN    = 15,
  parameter int EXP_MAX    = 17,
  parameter int LOCK_FILT  = 4,
  parameter int ERR_W      = 3
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clk_meas,
  input  logic             meas_en,
  output logic             lock_ok,
  output logic             lock_lost,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid,
  output logic             freq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int WIN_W  = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int FILT_W = $clog2(LOCK_FILT + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILT);
  localparam logic [FILT_W-1:0] FILT_PRE  = FILT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  EXP_MIN_C = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  EXP_MAX_C = CNT_W'(EXP_MAX);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_MEASURE   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Lock synchronizer, filter and loss detection.
  logic              r_lock_s1;
  logic              r_lock_s2;
  logic [FILT_W-1:0] r_filt_cnt;
  logic              r_lock_ok;
  logic              r_lock_ok_d;
  logic              r_lock_lost;

  // clk_meas synchronizer and edge detector.
  logic              r_meas_s1;
  logic              r_meas_s2;
  logic              r_meas_s3;

  // Measurement FSM and window datapath.
  state_t            r_state;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  r_meas_cnt;
  logic              r_meas_valid;
  logic              r_freq_err;

  // Error accumulation.
  logic [ERR_W-1:0]  r_err_cnt;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic              w_lock_s;
  logic              w_edge;
  logic [CNT_W:0]    w_sum_ext;
  logic [CNT_W-1:0]  w_sum_sat;
  logic              w_out_of_range;
  logic              w_run;
  logic              w_win_done;
  logic              w_err_evt;

  // ---------------------------------------------------------------------------
  // pll_lock synchronizer and assert filter
  // ---------------------------------------------------------------------------
  // The filter only delays the rising edge. Any low on the synchronized lock
  // drops lock_ok on the next edge. lock_ok is loaded on the same edge that
  // moves the counter from LOCK_FILT-1 to LOCK_FILT. As a result it asserts
  // exactly LOCK_FILT cycles after lock_s rises. The filter runs regardless
  // of FSM state, so lock_ok is always meaningful.
  assign w_lock_s = r_lock_s2;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1   <= 1'b0;
      r_lock_s2   <= 1'b0;
      r_filt_cnt  <= '0;
      r_lock_ok   <= 1'b0;
      r_lock_ok_d <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock;
      r_lock_s2 <= r_lock_s1;

      if (!w_lock_s) begin
        r_filt_cnt <= '0;
        r_lock_ok  <= 1'b0;
      end else begin
        if (r_filt_cnt != FILT_MAX) begin
          r_filt_cnt <= r_filt_cnt + FILT_W'(1);
        end
        r_lock_ok <= (r_filt_cnt >= FILT_PRE);
      end

      // The loss pulse is raised one cycle after lock_ok has fallen. A bounce
      // that never raised lock_ok therefore never produces a pulse.
      r_lock_ok_d <= r_lock_ok;
      r_lock_lost <= r_lock_ok_d & ~r_lock_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // clk_meas edge detection
  // ---------------------------------------------------------------------------
  // s1/s2 form the synchronizer, and s3 is the history bit for rising-edge
  // detection. The phase between the two clocks is unknown, so a window may
  // count one edge more or one edge fewer than the ideal ratio.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_s1 <= 1'b0;
      r_meas_s2 <= 1'b0;
      r_meas_s3 <= 1'b0;
    end else begin
      r_meas_s1 <= clk_meas;
      r_meas_s2 <= r_meas_s1;
      r_meas_s3 <= r_meas_s2;
    end
  end

  assign w_edge = r_meas_s2 & ~r_meas_s3;

  // ---------------------------------------------------------------------------
  // Window arithmetic
  // ---------------------------------------------------------------------------
  // The running count including this cycle's edge. It saturates instead of
  // wrapping, so a runaway clock still reads as out of range.
  assign w_sum_ext      = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_edge};
  assign w_sum_sat      = w_sum_ext[CNT_W] ? CNT_MAX : w_sum_ext[CNT_W-1:0];
  assign w_out_of_range = (w_sum_sat < EXP_MIN_C) | (w_sum_sat > EXP_MAX_C);

  // The window only advances in MEASURE, and only while neither abort
  // condition is present.
  assign w_run      = (r_state == S_MEASURE) & meas_en & r_lock_ok;
  assign w_win_done = w_run & (r_win_cnt == WIN_LAST);

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  // IDLE      : wait for meas_en.
  // WAIT_LOCK : wait for the filtered lock, then open a fresh window.
  // MEASURE   : count edges. Disabling wins over losing lock. Either abort
  //             discards the partial window, and the last result is kept.
  // Windows run back to back. The cycle after the final window cycle is
  // already cycle 0 of the next window, and an edge in that cycle counts
  // toward the next window.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_meas_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_freq_err   <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (meas_en) begin
            r_state <= S_WAIT_LOCK;
          end
        end

        S_WAIT_LOCK: begin
          if (!meas_en) begin
            r_state <= S_IDLE;
          end else if (r_lock_ok) begin
            r_state    <= S_MEASURE;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
          end
        end

        S_MEASURE: begin
          if (!meas_en) begin
            r_state <= S_IDLE;
          end else if (!r_lock_ok) begin
            r_state <= S_WAIT_LOCK;
          end else if (w_win_done) begin
            r_meas_cnt   <= w_sum_sat;
            r_freq_err   <= w_out_of_range;
            r_meas_valid <= 1'b1;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
          end else begin
            r_win_cnt  <= r_win_cnt + WIN_W'(1);
            r_edge_cnt <= w_sum_sat;
          end
        end

        // The unused encoding falls back to IDLE.
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
  // Two events count: a window closing out of range, and a lock loss while
  // enabled. If both occur in the same cycle, they count once. The counter
  // sticks at full scale until reset.
  assign w_err_evt = (w_win_done & w_out_of_range) | (r_lock_lost & meas_en);

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err_evt && (r_err_cnt != ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign lock_ok    = r_lock_ok;
  assign lock_lost  = r_lock_lost;
  assign meas_cnt   = r_meas_cnt;
  assign meas_valid = r_meas_valid;
  assign freq_err   = r_freq_err;
  assign err_cnt    = r_err_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_pll_clk_monitor.sv
//-----------------------------------------------------------------------------
// tb_pll_clk_monitor
//
// Bench for pll_clk_monitor. clk_tb runs at 500 MHz (2 ns period). clk_meas
// has a programmable half period. Each scenario task pushes the expected
// window results (edge-count range, freq_err, err_cnt) into exp_q before the
// window closes. The tick() task pops and compares one entry on every
// meas_valid pulse.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_clk_monitor;

  localparam int WIN_CYCLES = 1000;
  localparam int CNT_W      = 16;
  localparam int EXP_MIN    = 15;
  localparam int EXP_MAX    = 17;
  localparam int LOCK_FILT  = 4;
  localparam int ERR_W      = 3;
  localparam int ERR_SAT    = (1 << ERR_W) - 1;
  localparam int SB_W       = ERR_W + 1 + 2 * CNT_W;

  // Clock / reset / inputs
  logic clk_tb   = 1'b0;
  logic rst_n    = 1'b0;
  logic pll_lock = 1'b0;
  logic clk_meas = 1'b0;
  logic meas_en  = 1'b0;

  // DUT outputs
  logic             lock_ok;
  logic             lock_lost;
  logic [CNT_W-1:0] meas_cnt;
  logic             meas_valid;
  logic             freq_err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       state;

  realtime meas_half = 62.5;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_valid   = 0;
  int model_err = 0;

  // Entry layout: {err_cnt, freq_err, cnt_lo, cnt_hi}
  logic [SB_W-1:0] exp_q[$];

  pll_clk_monitor #(
    .WIN_CYCLES (WIN_CYCLES),
    .CNT_W      (CNT_W),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX),
    .LOCK_FILT  (LOCK_FILT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk_tb     (clk_tb),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .clk_meas   (clk_meas),
    .meas_en    (meas_en),
    .lock_ok    (lock_ok),
    .lock_lost  (lock_lost),
    .meas_cnt   (meas_cnt),
    .meas_valid (meas_valid),
    .freq_err   (freq_err),
    .err_cnt    (err_cnt),
    .state      (state)
  );

  // ---------------------------------------------------------------------------
  // Clocks
  // ---------------------------------------------------------------------------
  always #1 clk_tb = ~clk_tb;
  always #(meas_half) clk_meas = ~clk_meas;

  // ---------------------------------------------------------------------------
  // Scoreboard: advance one cycle (sampling at the falling edge), then check
  // any window result against the head of the queue.
  // ---------------------------------------------------------------------------
  task automatic tick();
    logic [SB_W-1:0]  e;
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
    @(negedge clk_tb);
    if (rst_n === 1'b1 && meas_valid === 1'b1) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_meas_valid: meas_valid=1 meas_cnt=%0d at %0t, required no window result", meas_cnt, $time);
      end else begin
        e  = exp_q.pop_front();
        lo = e[2*CNT_W-1 -: CNT_W];
        hi = e[CNT_W-1:0];
        if (meas_cnt < lo || meas_cnt > hi) begin
          n_fail++;
          $display("FAIL win_meas_cnt: meas_cnt=%0d, required %0d..%0d", meas_cnt, lo, hi);
        end
        n_checks++;
        if (freq_err !== e[2*CNT_W]) begin
          n_fail++;
          $display("FAIL win_freq_err: freq_err=%b, required %b", freq_err, e[2*CNT_W]);
        end
        n_checks++;
        if (err_cnt !== e[SB_W-1 -: ERR_W]) begin
          n_fail++;
          $display("FAIL win_err_cnt: err_cnt=%0d, required %0d", err_cnt, e[SB_W-1 -: ERR_W]);
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  // Expected result for one window at the current clk_meas frequency:
  // ideal count = window time / clk_meas period, with a tolerance of +/-1.
  task automatic push_window();
    int              nom;
    logic            bad;
    logic [SB_W-1:0] e;
    nom = int'((2.0 * WIN_CYCLES) / (2.0 * meas_half));
    bad = (nom < EXP_MIN) || (nom > EXP_MAX);
    if (bad && model_err < ERR_SAT) model_err++;
    e = {ERR_W'(model_err), bad, CNT_W'(nom - 1), CNT_W'(nom + 1)};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d windows pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    meas_en  = 1'b0;
    pll_lock = 1'b0;
    exp_q.delete();
    model_err = 0;
    repeat (3) @(negedge clk_tb);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (state !== 2'd0 || lock_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL por_state: state=%0d lock_ok=%b, required 0 0", state, lock_ok);
    end
    meas_half = 62.5;
    pll_lock  = 1'b1;
    meas_en   = 1'b1;
    push_window();
    wait_drain(WIN_CYCLES + 200, "reset_prewin");
    cyc(300);
    // Asynchronous assertion away from any clock edge.
    #0.3 rst_n = 1'b0;
    #0.2;
    n_checks++;
    if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL rst_lock_ok: lock_ok=%b, required 0", lock_ok); end
    n_checks++;
    if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL rst_lock_lost: lock_lost=%b, required 0", lock_lost); end
    n_checks++;
    if (meas_cnt !== '0) begin n_fail++; $display("FAIL rst_meas_cnt: meas_cnt=%0d, required 0", meas_cnt); end
    n_checks++;
    if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL rst_meas_valid: meas_valid=%b, required 0", meas_valid); end
    n_checks++;
    if (freq_err !== 1'b0) begin n_fail++; $display("FAIL rst_freq_err: freq_err=%b, required 0", freq_err); end
    n_checks++;
    if (err_cnt !== '0) begin n_fail++; $display("FAIL rst_err_cnt: err_cnt=%0d, required 0", err_cnt); end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: state=%0d, required 0", state); end
    @(negedge clk_tb);
    rst_n = 1'b1;
    cyc(6);
    n_checks++;
    if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL rst_relock: lock_ok=%b 6 cycles after release, required 1", lock_ok); end
  endtask

  task automatic test_nominal();
    do_reset();
    meas_half = 62.5;
    pll_lock  = 1'b1;
    meas_en   = 1'b1;
    cyc(5);
    n_checks++;
    if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL nom_lock_early: lock_ok=%b at edge 5, required 0", lock_ok); end
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL nom_wait_state: state=%0d, required 1", state); end
    cyc(1);
    n_checks++;
    if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL nom_lock_edge6: lock_ok=%b at edge 6, required 1", lock_ok); end
    cyc(1);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL nom_meas_state: state=%0d, required 2", state); end
    for (int i = 0; i < 10; i++) push_window();
    wait_drain(10 * WIN_CYCLES + 200, "nom_windows");
    n_checks++;
    if (err_cnt !== '0) begin n_fail++; $display("FAIL nom_err_cnt: err_cnt=%0d, required 0", err_cnt); end
    n_checks++;
    if (freq_err !== 1'b0) begin n_fail++; $display("FAIL nom_freq_err: freq_err=%b, required 0", freq_err); end
  endtask

  task automatic test_over_freq();
    do_reset();
    meas_half = 31.25;
    pll_lock  = 1'b1;
    meas_en   = 1'b1;
    for (int i = 0; i < 9; i++) push_window();
    wait_drain(9 * WIN_CYCLES + 200, "over_windows");
    n_checks++;
    if (err_cnt !== ERR_W'(ERR_SAT)) begin n_fail++; $display("FAIL over_err_sat: err_cnt=%0d, required %0d", err_cnt, ERR_SAT); end
    n_checks++;
    if (freq_err !== 1'b1) begin n_fail++; $display("FAIL over_freq_err: freq_err=%b, required 1", freq_err); end
  endtask

  task automatic test_lock_drop();
    int v0;
    int lost;
    int saw_wait;
    int relock;
    do_reset();
    meas_half = 62.5;
    pll_lock  = 1'b1;
    meas_en   = 1'b1;
    push_window();
    wait_drain(WIN_CYCLES + 200, "drop_first");
    cyc(500);
    v0       = n_valid;
    lost     = 0;
    saw_wait = 0;
    relock   = 0;
    pll_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (lock_lost === 1'b1) lost++;
      if (state === 2'd1) saw_wait = 1;
    end
    pll_lock = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (lock_lost === 1'b1) lost++;
      if (state === 2'd1) saw_wait = 1;
      if (state === 2'd2 && relock == 0) relock = i + 1;
    end
    n_checks++;
    if (lost !== 1) begin n_fail++; $display("FAIL drop_lock_lost: %0d pulses, required 1", lost); end
    n_checks++;
    if (saw_wait !== 1) begin n_fail++; $display("FAIL drop_state_wait: WAIT_LOCK seen=%0d, required 1", saw_wait); end
    n_checks++;
    if (relock !== 7) begin n_fail++; $display("FAIL drop_remeasure: MEASURE after %0d cycles, required 7", relock); end
    n_checks++;
    if (err_cnt !== ERR_W'(1)) begin n_fail++; $display("FAIL drop_err_cnt: err_cnt=%0d, required 1", err_cnt); end
    model_err++;
    push_window();
    cyc(900);
    n_checks++;
    if (n_valid !== v0) begin n_fail++; $display("FAIL drop_no_valid: %0d results since drop, required 0", n_valid - v0); end
    wait_drain(300, "drop_next");
  endtask

  task automatic test_bounce();
    int ok_hi;
    int lost;
    int bad_state;
    do_reset();
    meas_half = 62.5;
    meas_en   = 1'b1;
    cyc(2);
    ok_hi     = 0;
    lost      = 0;
    bad_state = 0;
    for (int r = 0; r < 6; r++) begin
      pll_lock = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (lock_ok === 1'b1) ok_hi++;
        if (lock_lost === 1'b1) lost++;
        if (state !== 2'd1) bad_state++;
      end
      pll_lock = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (lock_ok === 1'b1) ok_hi++;
        if (lock_lost === 1'b1) lost++;
        if (state !== 2'd1) bad_state++;
      end
    end
    n_checks++;
    if (ok_hi !== 0) begin n_fail++; $display("FAIL bounce_lock_ok: lock_ok high %0d cycles, required 0", ok_hi); end
    n_checks++;
    if (lost !== 0) begin n_fail++; $display("FAIL bounce_lock_lost: %0d pulses, required 0", lost); end
    n_checks++;
    if (bad_state !== 0) begin n_fail++; $display("FAIL bounce_state: %0d cycles not in WAIT_LOCK, required 0", bad_state); end
    n_checks++;
    if (err_cnt !== '0) begin n_fail++; $display("FAIL bounce_err_cnt: err_cnt=%0d, required 0", err_cnt); end
  endtask

  task automatic test_en_drop();
    int v0;
    int lost;
    do_reset();
    meas_half = 31.25;
    pll_lock  = 1'b1;
    meas_en   = 1'b1;
    push_window();
    wait_drain(WIN_CYCLES + 200, "en_first");
    cyc(500);
    v0      = n_valid;
    meas_en = 1'b0;
    cyc(1);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL en_idle: state=%0d, required 0", state); end
    cyc(1100);
    n_checks++;
    if (n_valid !== v0) begin n_fail++; $display("FAIL en_no_valid: %0d results after disable, required 0", n_valid - v0); end
    n_checks++;
    if (err_cnt !== ERR_W'(1)) begin n_fail++; $display("FAIL en_err_hold: err_cnt=%0d, required 1", err_cnt); end
    n_checks++;
    if (meas_cnt < CNT_W'(31) || meas_cnt > CNT_W'(33)) begin n_fail++; $display("FAIL en_cnt_hold: meas_cnt=%0d, required 31..33", meas_cnt); end
    n_checks++;
    if (freq_err !== 1'b1) begin n_fail++; $display("FAIL en_ferr_hold: freq_err=%b, required 1", freq_err); end
    lost     = 0;
    pll_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (lock_lost === 1'b1) lost++;
    end
    n_checks++;
    if (lost !== 1) begin n_fail++; $display("FAIL en_lock_lost: %0d pulses, required 1", lost); end
    n_checks++;
    if (err_cnt !== ERR_W'(1)) begin n_fail++; $display("FAIL en_lost_err: err_cnt=%0d, required 1", err_cnt); end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL en_lost_state: state=%0d, required 0", state); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_nominal();
    test_over_freq();
    test_lock_drop();
    test_bounce();
    test_en_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pll_clk_monitor.md
Name: pll_clk_monitor

Overview:
- Sits directly downstream of the PLL2 instance.
- Consumes the PLL's pll_lock and one PLL output clock (clk_meas).
- Filters the lock indication, counts clk_meas rising edges over fixed windows of clk_tb cycles, and range-checks each count.
- Provides a self-checking lock/frequency result with a saturating error counter for the PLL bench and later board bring-up.

Parameters:
- WIN_CYCLES, 1000: clk_tb cycles per measurement window (≥2).
- CNT_W, 16: width of the edge counter and meas_cnt.
- EXP_MIN, 15: minimum legal edge count per window (inclusive).
- EXP_MAX, 17: maximum legal edge count per window (inclusive).
- LOCK_FILT, 4: consecutive synchronized-high cycles required before lock_ok asserts (≥1).
- ERR_W, 3: width of err_cnt.

Ports:
- clk_tb  in  1  monitor clock, 500 MHz in bench; must exceed 2x clk_meas frequency.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL lock, asynchronous to clk_tb.
- clk_meas  in  1  PLL output clock under test, asynchronous.
- meas_en  in  1  enables measurement and error accumulation.
- lock_ok  out  1  filtered lock.
- lock_lost  out  1  one-cycle pulse on lock_ok 1->0.
- meas_cnt  out  CNT_W  edge count of the last completed window.
- meas_valid  out  1  one-cycle pulse when meas_cnt/freq_err update.
- freq_err  out  1  last completed window was out of [EXP_MIN, EXP_MAX].
- err_cnt  out  ERR_W  saturating error event count.
- state  out  2  FSM state: 0 IDLE, 1 WAIT_LOCK, 2 MEASURE; 3 unused, recovers to IDLE.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, all sync flops/counters 0. Reset mid-window discards the window with no meas_valid.
- pll_lock synchronizer and filter:
  - pll_lock passes through a 2-flop synchronizer to give lock_s.
  - Filter counter increments while lock_s=1 and saturates at LOCK_FILT.
  - lock_ok rises on the clk_tb edge where the counter reaches LOCK_FILT: LOCK_FILT cycles after lock_s rises, i.e. 2+LOCK_FILT edges after pll_lock is first sampled high.
  - lock_s=0 clears the counter and drops lock_ok on the next edge; there is no deassert filtering.
  - The filter runs in all states.
- lock_lost: registered pulse on the cycle after lock_ok falls, in any state. A bounce shorter than LOCK_FILT never raises lock_ok and never produces lock_lost.
- clk_meas edge detect: 3-flop chain; edge = s2 & ~s3. This gives 2-3 cycles of latency, and a ±1 edge count error per window is expected.
- FSM:
  - IDLE: meas_en=1 -> WAIT_LOCK.
  - WAIT_LOCK: meas_en=0 -> IDLE; lock_ok=1 -> MEASURE, clearing win_cnt and edge_cnt.
  - MEASURE: meas_en=0 -> IDLE (abort); lock_ok=0 -> WAIT_LOCK (abort); otherwise run the window. meas_en=0 has priority over lock loss.
- Window:
  - win_cnt runs 0..WIN_CYCLES-1; edge_cnt accumulates edges and saturates at 2^CNT_W-1.
  - On the cycle where win_cnt=WIN_CYCLES-1:
    - on the next edge, meas_cnt <= edge_cnt + edge (saturating), freq_err <= (sum<EXP_MIN)|(sum>EXP_MAX), and meas_valid pulses;
    - win_cnt and edge_cnt restart at 0 with no gap cycle, so windows are back-to-back;
    - an edge on the restart cycle counts in the new window.
  - An aborted window produces no meas_valid; meas_cnt and freq_err hold their last values.
- err_cnt increments by 1 on:
  - a meas_valid with freq_err computed 1, or
  - a lock_lost pulse while meas_en=1.
  - Both events on the same cycle still increment by 1 total (cannot normally coincide).
  - Saturates at 2^ERR_W-1 and holds until reset.

Test Plan:
1. Reset: assert rst_n=0 mid-run with pll_lock=1 and clk_meas toggling -> all outputs 0 immediately and state=0; after release, lock_ok returns 0->1 within 6 cycles.
2. Nominal: clk_meas period 125 ns (8 MHz), pll_lock=1, meas_en=1 -> lock_ok at edge 6, state=2, meas_valid every 1000 cycles, meas_cnt in 15..17, freq_err=0, err_cnt=0 after 10 windows.
3. Over-frequency: clk_meas period 62.5 ns -> meas_cnt in 31..33, freq_err=1, err_cnt increments each window to 7 and holds at 7.
4. Lock drop mid-window: pll_lock low for 10 cycles at window cycle 500 ->
   - lock_lost single pulse;
   - state 2->1->2;
   - no meas_valid for the aborted window;
   - err_cnt +1;
   - the next window starts after lock_ok re-asserts (4+2 cycles) and reports 15..17.
5. Lock bounce: pll_lock high for 3 cycles then low, repeated -> lock_ok stays 0, lock_lost never pulses, state stays 1, err_cnt=0.
6. meas_en drop mid-window -> state=0 next cycle, no meas_valid, err_cnt unchanged; a later lock loss with meas_en=0 pulses lock_lost but err_cnt stays unchanged.
